build_info_uart_tx: RTL and testbench

Serialises the build-identification words (64-bit git hash, 32-bit timestamp) as one ASCII line over a UART TX pin, so the values can be read on a host terminal without a processor. The block sits in top_io beside the user_init_* instances and takes their value_o outputs. It is the readout side of the values those instances produce. Transmission is triggered by a one-cycle start pulse and runs autonomously to completion.

---
 rtl/build_info_uart_tx.sv | 135 +++++++++++++
 tb/tb_build_info_uart_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/build_info_uart_tx.sv
// build_info_uart_tx: sends "H:<git hash> T:<timestamp>\r\n" as uppercase hex over a UART TX line.
// 8N1 by default; define BUILD_INFO_UART_PARITY_EN for 8E1 framing.
module build_info_uart_tx #(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic        clk100,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [63:0] git_hash_i,
  input  logic [31:0] timestamp_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] CHAR_LAST = 5'd30;
`ifdef BUILD_INFO_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_PARITY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [4:0]    r_char;
  logic [63:0]   r_hash;
  logic [31:0]   r_ts;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    w_hsel;
  logic [2:0]    w_tsel;
  logic [3:0]    w_nib;
  logic [7:0]    w_hex;
  logic [7:0]    w_char;
  logic          w_tick;
  // Chars 2..17 are hash nibbles and 21..28 timestamp nibbles, most significant first.
  always_comb begin
    w_hsel = 4'(5'd17 - r_char);
    w_tsel = 3'(5'd28 - r_char);
    w_nib  = (r_char <= 5'd17) ? r_hash[{w_hsel, 2'b00} +: 4] : r_ts[{w_tsel, 2'b00} +: 4];
    w_hex  = (w_nib < 4'd10) ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
    w_char = (r_char == 5'd0)  ? 8'h48 :
             (r_char == 5'd1)  ? 8'h3A :
             (r_char <= 5'd17) ? w_hex :
             (r_char == 5'd18) ? 8'h20 :
             (r_char == 5'd19) ? 8'h54 :
             (r_char == 5'd20) ? 8'h3A :
             (r_char <= 5'd28) ? w_hex :
             (r_char == 5'd29) ? 8'h0D : 8'h0A;
    w_tick = (r_baud == BAUD_LAST);
  end
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_char  <= '0;
      r_hash  <= '0;
      r_ts    <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start_i) begin
          r_hash  <= git_hash_i;
          r_ts    <= timestamp_i;
          r_baud  <= '0;
          r_bit   <= '0;
          r_char  <= '0;
          r_state <= S_START;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else begin
        r_baud <= w_tick ? '0 : r_baud + BW'(1);
        // The line register is loaded with the next bit as the current one ends.
        if (w_tick) begin
          case (r_state)
            S_START: begin
              r_state <= S_DATA;
              r_tx    <= w_char[0];
            end
            S_DATA: begin
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
`ifdef BUILD_INFO_UART_PARITY_EN
                r_state <= S_PARITY;
                r_tx    <= ^w_char;
`else
                r_state <= S_STOP;
                r_tx    <= 1'b1;
`endif
              end else begin
                r_tx <= w_char[r_bit + 3'd1];
              end
            end
`ifdef BUILD_INFO_UART_PARITY_EN
            S_PARITY: begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end
`endif
            S_STOP: begin
              if (r_char == CHAR_LAST) begin
                r_state <= S_IDLE;
                r_char  <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_tx    <= 1'b1;
              end else begin
                r_state <= S_START;
                r_char  <= r_char + 5'd1;
                r_tx    <= 1'b0;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
            end
          endcase
        end
      end
    end
  end
  assign uart_tx_o = r_tx;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
endmodule

// File: tb/tb_build_info_uart_tx.sv
// tb_build_info_uart_tx: directed and randomized checks of the build-info UART line against a string model.
module tb_build_info_uart_tx;
  localparam int CPB = 16;
`ifdef BUILD_INFO_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int TOT = 31 * FB * CPB;
  logic        clk100 = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [63:0] git_hash = '0;
  logic [31:0] timestamp = '0;
  logic        uart_tx, busy, done;
  int          checks = 0;
  int          errors = 0;
  logic        cap[TOT+3];
  logic [7:0]  msg[$];
  build_info_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(1)) dut (
    .clk100(clk100), .rstn(rstn), .start_i(start), .git_hash_i(git_hash),
    .timestamp_i(timestamp), .uart_tx_o(uart_tx), .busy_o(busy), .done_o(done)
  );
  always #5 clk100 = ~clk100;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction
  task automatic build_msg(input logic [63:0] h, input logic [31:0] t);
    msg = {8'h48, 8'h3A};
    for (int d = 15; d >= 0; d--) msg.push_back(hexc(4'(h >> (4 * d))));
    msg.push_back(8'h20);
    msg.push_back(8'h54);
    msg.push_back(8'h3A);
    for (int d = 7; d >= 0; d--) msg.push_back(hexc(4'(t >> (4 * d))));
    msg.push_back(8'h0D);
    msg.push_back(8'h0A);
  endtask
  // Entered at a falling edge; with do_start=0 the previous call has already issued the start.
  task automatic run_msg(input logic [63:0] h, input logic [31:0] t, input bit do_start, input bit noise, input bit chain);
    int nb, nd, di, last, bad;
    logic [FB-1:0] fbits;
    logic [7:0] obs;
    nb = 0; nd = 0; di = -1;
    last = chain ? TOT : TOT + 2;
    build_msg(h, t);
    if (do_start) begin
      git_hash = h; timestamp = t; start = 1'b1;
      @(negedge clk100);
      start = 1'b0;
    end
    for (int i = 0; i <= last; i++) begin
      cap[i] = uart_tx;
      if (busy) nb++;
      if (done) begin nd++; di = i; end
      if (noise) begin
        if (i == 1) begin git_hash = '1; timestamp = $urandom; end
        start = (i == 100 || i == 2000);
      end
      if (chain && i == TOT) begin git_hash = h; timestamp = t; start = 1'b1; end
      @(negedge clk100);
    end
    start = 1'b0;
    chk("busy_cycles", 64'(nb), 64'(TOT));
    chk("done_count", 64'(nd), 64'd1);
    chk("done_index", 64'(di), 64'(TOT));
    chk("tx_in_done_cycle", 64'(cap[TOT]), 64'd1);
    if (!chain) chk("tx_idle_after", 64'(cap[TOT+1] & cap[TOT+2]), 64'd1);
    for (int k = 0; k < 31; k++) begin
      fbits = '0;
      fbits[8:1] = msg[k];
      fbits[FB-1] = 1'b1;
`ifdef BUILD_INFO_UART_PARITY_EN
      fbits[9] = ^msg[k];
`endif
      bad = 0;
      for (int j = 0; j < FB; j++)
        for (int c = 0; c < CPB; c++)
          if (cap[(k * FB + j) * CPB + c] !== fbits[j]) bad++;
      for (int j = 0; j < 8; j++) obs[j] = cap[(k * FB + 1 + j) * CPB + CPB / 2];
      chk($sformatf("char%0d", k), 64'(obs), 64'(msg[k]));
      chk($sformatf("wave%0d", k), 64'(bad), 64'd0);
    end
  endtask
  initial begin
    int cnt;
    logic [63:0] rh;
    logic [31:0] rt;
    repeat (3) @(negedge clk100);
    chk("rst_tx", 64'(uart_tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) cnt++;
      @(negedge clk100);
    end
    chk("idle_line", 64'(cnt), 64'd0);
    run_msg(64'h0123456789ABCDEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    run_msg(64'h0123456789ABCDEF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    run_msg(64'hFFFFFFFFFFFFFFFF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    rh = {$urandom, $urandom};
    rt = $urandom;
    run_msg(rh, rt, 1'b1, 1'b0, 1'b1);
    run_msg(rh, rt, 1'b0, 1'b0, 1'b0);
    git_hash = {$urandom, $urandom};
    timestamp = $urandom;
    start = 1'b1;
    @(negedge clk100);
    start = 1'b0;
    repeat (5 * FB * CPB + 4 * CPB + 5) @(negedge clk100);
    chk("busy_mid_char5", 64'(busy), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_tx", 64'(uart_tx), 64'd1);
    chk("async_rst_busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      if (done !== 1'b0 || uart_tx !== 1'b1) cnt++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      if (done !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1) cnt++;
    end
    chk("after_rst_quiet", 64'(cnt), 64'd0);
    rh = {$urandom, $urandom};
    rt = $urandom;
    run_msg(rh, rt, 1'b1, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
